// File: rtl/mole_game_core.sv
// Whack-a-mole game engine: synchronised switch toggles score against LFSR-driven moles,
// with lives and an IDLE/PLAY/OVER state machine. Define STREAK_BONUS_EN for double-point streaks.
module mole_game_core #(
  parameter int          N_HOLES    = 8,
  parameter int          SCORE_W    = 8,
  parameter int          MOLE_TICKS = 4,
  parameter int          LIVES      = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic [N_HOLES-1:0] sw,
  output logic [N_HOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic [1:0]         state,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  localparam int TW = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;
  localparam int EW = SCORE_W + 5;

  state_t             state_q,  state_d;
  logic [N_HOLES-1:0] sync1_q,  sync1_d;
  logic [N_HOLES-1:0] sync2_q,  sync2_d;
  logic [N_HOLES-1:0] prev_q,   prev_d;
  logic [N_HOLES-1:0] mole_q,   mole_d;
  logic [SCORE_W-1:0] score_q,  score_d;
  logic [3:0]         lives_q,  lives_d;
  logic [15:0]        lfsr_q,   lfsr_d;
  logic [TW-1:0]      timer_q,  timer_d;
`ifdef STREAK_BONUS_EN
  logic [2:0]         streak_q, streak_d;
  logic               in_round_q, in_round_d;
`endif

  logic [N_HOLES-1:0] toggle_w;
  logic [N_HOLES-1:0] hit_w;
  logic [N_HOLES-1:0] wrong_w;
  logic [N_HOLES-1:0] mole_left_w;
  logic [5:0]         hit_cnt_w;
  logic [5:0]         wrong_cnt_w;
  logic [5:0]         pts_w;
  logic [EW-1:0]      score_ext_w;
  logic [EW-1:0]      pts_ext_w;
  logic [EW-1:0]      wrong_ext_w;
  logic signed [EW-1:0] sum_w;
  logic [SCORE_W-1:0] score_sat_w;
  logic [15:0]        lfsr_next_w;
  logic [N_HOLES-1:0] new_mole_w;
  logic               miss_w;

  function automatic logic [5:0] popcnt(input logic [N_HOLES-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      c = c + {5'b0, v[i]};
    end
    return c;
  endfunction

  // Datapath shared by all states: toggle detection, scoring arithmetic, next pattern.
  always_comb begin
    sync1_d     = sw;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    toggle_w    = sync2_q ^ prev_q;
    hit_w       = toggle_w & mole_q;
    wrong_w     = toggle_w & ~mole_q;
    mole_left_w = mole_q & ~hit_w;
    hit_cnt_w   = popcnt(hit_w);
    wrong_cnt_w = popcnt(wrong_w);
`ifdef STREAK_BONUS_EN
    pts_w       = (streak_q >= 3'd4) ? (hit_cnt_w << 1) : hit_cnt_w;
`else
    pts_w       = hit_cnt_w;
`endif
    score_ext_w       = '0;
    score_ext_w[SCORE_W-1:0] = score_q;
    pts_ext_w         = '0;
    pts_ext_w[5:0]    = pts_w;
    wrong_ext_w       = '0;
    wrong_ext_w[5:0]  = wrong_cnt_w;
    sum_w = $signed(score_ext_w) + $signed(pts_ext_w) - $signed(wrong_ext_w);
    if (sum_w < 0) begin
      score_sat_w = '0;
    end else if (sum_w > $signed({5'b0, {SCORE_W{1'b1}}})) begin
      score_sat_w = '1;
    end else begin
      score_sat_w = sum_w[SCORE_W-1:0];
    end
    lfsr_next_w = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    new_mole_w  = (lfsr_q[N_HOLES-1:0] == '0) ? N_HOLES'(1) : lfsr_q[N_HOLES-1:0];
    miss_w      = |mole_left_w;
  end

  always_comb begin
    state_d = state_q;
    mole_d  = mole_q;
    score_d = score_q;
    lives_d = lives_q;
    lfsr_d  = lfsr_q;
    timer_d = timer_q;
`ifdef STREAK_BONUS_EN
    streak_d   = streak_q;
    in_round_d = in_round_q;
`endif
    case (state_q)
      S_PLAY: begin
        score_d = score_sat_w;
        mole_d  = mole_left_w;
`ifdef STREAK_BONUS_EN
        if (wrong_w != '0) begin
          streak_d = 3'd0;
        end
`endif
        if (tick) begin
          if (timer_q == '0) begin
            // Hits are already removed from the old pattern, so the miss check is fair.
            if (miss_w && (lives_q != 4'd0)) begin
              lives_d = lives_q - 4'd1;
            end
            mole_d  = new_mole_w;
            timer_d = TW'(MOLE_TICKS - 1);
            lfsr_d  = lfsr_next_w;
`ifdef STREAK_BONUS_EN
            in_round_d = 1'b1;
            if (miss_w) begin
              streak_d = 3'd0;
            end else if (in_round_q && (wrong_w == '0) && (streak_q != 3'd7)) begin
              streak_d = streak_q + 3'd1;
            end
`endif
            if (miss_w && (lives_q == 4'd1)) begin
              state_d = S_OVER;
              mole_d  = '0;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      default: begin
        mole_d = '0;
        if (start) begin
          state_d = S_PLAY;
          score_d = '0;
          lives_d = 4'(LIVES);
          lfsr_d  = LFSR_SEED;
          timer_d = '0;
`ifdef STREAK_BONUS_EN
          streak_d   = 3'd0;
          in_round_d = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      mole_q  <= '0;
      score_q <= '0;
      lives_q <= 4'(LIVES);
      lfsr_q  <= LFSR_SEED;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      mole_q  <= mole_d;
      score_q <= score_d;
      lives_q <= lives_d;
      lfsr_q  <= lfsr_d;
      timer_q <= timer_d;
    end
  end

`ifdef STREAK_BONUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q   <= 3'd0;
      in_round_q <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      in_round_q <= in_round_d;
    end
  end
`endif

  assign mole      = mole_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign state     = state_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core: default 8-hole instance plus a 1-hole, 4-bit-score
// instance that exercises score saturation.
module tb_mole_game_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, start;
  logic [7:0] sw;
  logic [7:0] mole;
  logic [7:0] score;
  logic [3:0] lives;
  logic [1:0] state;
  logic       game_over;

  logic       tick2, start2;
  logic [0:0] sw2;
  logic [0:0] mole2;
  logic [3:0] score2;
  logic [3:0] lives2;
  logic [1:0] state2;
  logic       go2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mole_game_core dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .sw(sw),
    .mole(mole), .score(score), .lives(lives), .state(state), .game_over(game_over)
  );

  mole_game_core #(.N_HOLES(1), .SCORE_W(4), .MOLE_TICKS(1), .LIVES(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .tick(tick2), .start(start2), .sw(sw2),
    .mole(mole2), .score(score2), .lives(lives2), .state(state2), .game_over(go2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step(1); tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic flip(input logic [7:0] m);
    sw = sw ^ m; step(3);
  endtask

  initial begin
    rst_n = 1'b1; tick = 0; start = 0; sw = '0;
    tick2 = 0; start2 = 0; sw2 = '0;
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_state", state, 2'b00);
    chk("rst_mole", mole, 8'h00);
    chk("rst_score", score, 8'h00);
    chk("rst_lives", lives, 4'd3);
    chk("rst_game_over", game_over, 1'b0);
    rst_n = 1'b1;
    step(1);

    // Saturation on the 4-bit instance: one mole per tick, hit every round.
    start2 = 1'b1; step(1); start2 = 1'b0;
    chk("sat_state", state2, 2'b01);
    for (int i = 0; i < 16; i++) begin
      tick2 = 1'b1; step(1); tick2 = 1'b0;
      chk($sformatf("sat_mole_%0d", i), mole2, 1'b1);
      sw2 = ~sw2; step(3);
      chk($sformatf("sat_score_%0d", i), score2, (i + 1 > 15) ? 15 : i + 1);
    end
    chk("sat_lives", lives2, 4'd3);
    chk("sat_mole_cleared", mole2, 1'b0);

    // Start and first round.
    pulse_start();
    chk("start_state", state, 2'b01);
    chk("start_lives", lives, 4'd3);
    chk("start_score", score, 8'h00);
    chk("start_mole", mole, 8'h00);
    pulse_tick();
    chk("round1_mole", mole, 8'hE1);
    chk("round1_state", state, 2'b01);

    // Hit two moles; score lands exactly 3 clk after the switch edge.
    sw = sw ^ 8'h21; step(2);
    chk("hit_latency_2clk", score, 8'h00);
    step(1);
    chk("hit_score", score, 8'h02);
    chk("hit_mole", mole, 8'hC0);

    flip(8'h02);
    chk("wrong_score_1", score, 8'h01);
    flip(8'h04);
    chk("wrong_score_0", score, 8'h00);
    flip(8'h08);
    chk("wrong_no_underflow", score, 8'h00);
    flip(8'h80);
    chk("hit7_score", score, 8'h01);
    chk("hit7_mole", mole, 8'h40);

    // Let three rounds expire with moles left standing.
    repeat (3) pulse_tick();
    chk("round1_end_pending", lives, 4'd3);
    pulse_tick();
    chk("miss1_lives", lives, 4'd2);
    chk("round2_mole", mole, 8'h70);
    repeat (4) pulse_tick();
    chk("miss2_lives", lives, 4'd1);
    chk("round3_mole", mole, 8'h38);
    repeat (4) pulse_tick();
    chk("over_lives", lives, 4'd0);
    chk("over_state", state, 2'b10);
    chk("over_flag", game_over, 1'b1);
    chk("over_mole", mole, 8'h00);
    chk("over_score_held", score, 8'h01);

    flip(8'h01);
    chk("over_toggle_ignored", score, 8'h01);
    pulse_tick();
    chk("over_tick_mole", mole, 8'h00);
    chk("over_tick_state", state, 2'b10);

    // Restart from OVER reinitialises everything.
    pulse_start();
    chk("restart_state", state, 2'b01);
    chk("restart_lives", lives, 4'd3);
    chk("restart_score", score, 8'h00);
    chk("restart_game_over", game_over, 1'b0);
    pulse_tick();
    chk("restart_mole", mole, 8'hE1);
    flip(8'h01);
    chk("restart_hit_score", score, 8'h01);
    chk("restart_hit_mole", mole, 8'hE0);

    // Asynchronous reset mid-PLAY, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 2'b00);
    chk("async_rst_mole", mole, 8'h00);
    chk("async_rst_score", score, 8'h00);
    chk("async_rst_lives", lives, 4'd3);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef STREAK_BONUS_EN
    step(4);
    pulse_start();
    pulse_tick();
    chk("streak_r1_mole", mole, 8'hE1);
    flip(8'hE1);
    chk("streak_r1_score", score, 8'd4);
    repeat (4) pulse_tick();
    chk("streak_r2_mole", mole, 8'h70);
    flip(8'h70);
    repeat (4) pulse_tick();
    chk("streak_r3_mole", mole, 8'h38);
    flip(8'h38);
    repeat (4) pulse_tick();
    chk("streak_r4_mole", mole, 8'h9C);
    flip(8'h9C);
    chk("streak_r4_score", score, 8'd14);
    repeat (4) pulse_tick();
    chk("streak_r5_mole", mole, 8'h4E);
    chk("streak_lives", lives, 4'd3);
    flip(8'h02);
    chk("streak_bonus_hit", score, 8'd16);
    flip(8'h01);
    chk("streak_wrong", score, 8'd15);
    flip(8'h04);
    chk("streak_cleared_hit", score, 8'd16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
